aes_inv_sub_bytes_seq: RTL and testbench
========================================

// Module: aes_inv_sub_bytes_seq
// PURPOSE
//  Iterative InvSubBytes engine for the AES decryption datapath: accepts one 128-bit state,
//  applies the inverse S-box to all 16 bytes over 16/LANES cycles, returns the result.
//  Each lane: inverse affine -> composite-field map -> GF(2^8) inverse -> inverse map.
//  Sits between InvShiftRows and AddRoundKey in the inverse-cipher round loop.
// PARAMETERS
//  LANES  4  bytes processed per cycle; legal values 1,2,4,8,16 (elaboration error otherwise)
// PORTS
//  clk        in   1    clock, all logic rising-edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    in_state valid
//  in_ready   out  1    engine can accept a state
//  in_state   in   128  input state, byte 0 = [127:120] ... byte 15 = [7:0]
//  out_valid  out  1    out_state holds a completed result
//  out_ready  in   1    downstream accepts result
//  out_state  out  128  InvSubBytes(in_state), same byte order
//  busy       out  1    high in BUSY state
// BEHAVIOUR
//  - Reset: state IDLE, out_valid=0, out_state=0, busy=0, byte counter=0, work reg=0.
//  - States: IDLE -> (in_valid&&in_ready) -> BUSY -> (last lane group written) -> DONE
//    -> (out_ready) -> IDLE, or BUSY directly if a new input is accepted in the same cycle.
//  - in_ready = (IDLE) || (DONE && out_ready); accept+release in one cycle is legal, no bubble.
//  - Accept: capture in_state into work reg, counter=0. BUSY: each cycle replace bytes
//    [counter*LANES +: LANES] with InvSbox(byte), counter += 1; at counter==16/LANES-1
//    go DONE. Counter width $clog2(16/LANES) (min 1 bit), wraps to 0 on accept.
//  - Latency: out_valid rises exactly 16/LANES cycles after the accepting edge
//    (LANES=16: 1 cycle).
//  - out_valid high only in DONE; out_state = work reg, held stable while out_valid && !out_ready.
//  - in_state / in_valid ignored while BUSY, or while in DONE with out_ready low.
//  - InvSbox(y) = GFinv(A^-1(y)); A^-1: b_i = y_(i+2)%8 ^ y_(i+5)%8 ^ y_(i+7)%8 ^ 0x05_i;
//    GFinv(0)=0. Purely combinational per lane, no internal pipeline stages.
//  - rst mid-operation: abandon work, return to reset values next edge; no partial result.
// CONFIGURATION
//  AES_FWD_SBOX_EN defined: extra port in_fwd (in, 1), captured at accept;
//    in_fwd=1 -> forward S-box (GFinv then forward affine, const 0x63) for that state.
//    Timing and handshake identical for both directions.
//  Undefined: no in_fwd port, inverse S-box only, forward affine logic not built.
// STRUCTURE
//  aes_pkg: aes_nibble typedef; constants AES_INV_AFF_C=8'h05, AES_AFF_C=8'h63;
//   functions inv_affine(), fwd_affine() (under macro), map_to_composite(),
//   map_from_composite() (isomorphism matrices); existing nibble helpers reused.
//  Sub-module aes_inv_sbox_lane: one byte in, one byte out (+fwd select under macro),
//   wraps the shared GF(2^8) inverter; instantiated LANES times via generate.
//  Top: FSM, counter, 128-bit work register, lane byte muxing.
// TESTING
//  1 in_state=all 8'h63, out_ready=1 -> out_state all 8'h00, out_valid at cycle 16/LANES.
//  2 bytes 0..3 = 63,7C,16,ED, rest 00 -> out bytes 00,01,FF,53, rest 52.
//  3 out_ready=0 for 10 cycles in DONE -> out_state stable, in_ready=0, new in_valid ignored;
//    then out_ready=1 with in_valid=1 -> same-cycle accept, next result after 16/LANES cycles.
//  4 rst asserted mid-BUSY -> next edge out_valid=0, out_state=0, busy=0, in_ready=1.
//  5 sweep all 256 byte values through each lane position vs. golden InvSbox table,
//    for LANES = 1, 4 and 16.
//  6 AES_FWD_SBOX_EN: in_fwd=1, byte 8'h53 -> 8'hED, 8'h00 -> 8'h63; in_fwd=0 -> inverse.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box helpers: affine transforms, GF(2^4)/GF((2^4)^2) arithmetic, basis maps.
// The basis-change matrices are derived at elaboration from a root of the AES polynomial.
package aes_pkg;

  typedef logic [3:0] aes_nibble;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } aes_state_e;

  localparam logic [7:0] AES_INV_AFF_C = 8'h05;
  localparam logic [7:0] AES_AFF_C     = 8'h63;
  // y^2 + y + lambda is irreducible over GF(2^4) because trace(0xC) = 1
  localparam aes_nibble  AES_LAMBDA    = 4'hC;

  function automatic aes_nibble gf16_mul(input aes_nibble a, input aes_nibble b);
    aes_nibble r, x, bb;
    r  = '0;
    x  = a;
    bb = b;
    for (int i = 0; i < 4; i++) begin
      if (bb[0]) r = r ^ x;
      x  = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic aes_nibble gf16_inv(input aes_nibble a);
    aes_nibble a2, a4, a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a2, a4), a8);
  endfunction

  function automatic logic [7:0] gf256c_mul(input logic [7:0] a, input logic [7:0] b);
    aes_nibble hh, rh, rl;
    hh = gf16_mul(a[7:4], b[7:4]);
    rh = hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]);
    rl = gf16_mul(hh, AES_LAMBDA) ^ gf16_mul(a[3:0], b[3:0]);
    return {rh, rl};
  endfunction

  // Shared inverter: multiply by the conjugate, invert the GF(2^4) norm.
  function automatic logic [7:0] gf256c_inv(input logic [7:0] a);
    aes_nibble n, ni;
    n  = gf16_mul(gf16_mul(a[7:4], a[7:4]), AES_LAMBDA) ^
         gf16_mul(a[7:4], a[3:0]) ^ gf16_mul(a[3:0], a[3:0]);
    ni = gf16_inv(n);
    return {gf16_mul(a[7:4], ni), gf16_mul(a[7:4] ^ a[3:0], ni)};
  endfunction

  function automatic logic [7:0] apply_matrix(input logic [63:0] m, input logic [7:0] a);
    logic [7:0]  r, aa;
    logic [63:0] mm;
    r  = '0;
    aa = a;
    mm = m;
    for (int i = 0; i < 8; i++) begin
      if (aa[0]) r = r ^ mm[7:0];
      aa = aa >> 1;
      mm = mm >> 8;
    end
    return r;
  endfunction

  function automatic logic [7:0] find_root();
    logic [7:0] b, b2, b3, b4, b8, p, r;
    logic       found;
    r     = 8'h02;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      b  = 8'(c);
      b2 = gf256c_mul(b, b);
      b3 = gf256c_mul(b2, b);
      b4 = gf256c_mul(b2, b2);
      b8 = gf256c_mul(b4, b4);
      p  = b8 ^ b4 ^ b3 ^ b ^ 8'h01;
      if (p == 8'h00 && !found) begin
        r     = b;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] build_iso();
    logic [63:0] m;
    logic [7:0]  beta, pw;
    beta = find_root();
    pw   = 8'h01;
    m    = '0;
    for (int i = 0; i < 8; i++) begin
      m  = {pw, m[63:8]};
      pw = gf256c_mul(pw, beta);
    end
    return m;
  endfunction

  function automatic logic [63:0] build_iso_inv(input logic [63:0] iso);
    logic [63:0] m;
    logic [7:0]  e, col;
    m = '0;
    e = 8'h01;
    for (int j = 0; j < 8; j++) begin
      col = '0;
      for (int p = 0; p < 256; p++) begin
        if (apply_matrix(iso, 8'(p)) == e) col = 8'(p);
      end
      m = {col, m[63:8]};
      e = e << 1;
    end
    return m;
  endfunction

  localparam logic [63:0] AES_ISO     = build_iso();
  localparam logic [63:0] AES_ISO_INV = build_iso_inv(AES_ISO);

  function automatic logic [7:0] map_to_composite(input logic [7:0] a);
    return apply_matrix(AES_ISO, a);
  endfunction

  function automatic logic [7:0] map_from_composite(input logic [7:0] a);
    return apply_matrix(AES_ISO_INV, a);
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    return {y[1:0], y[7:2]} ^ {y[4:0], y[7:5]} ^ {y[6:0], y[7]} ^ AES_INV_AFF_C;
  endfunction

`ifdef AES_FWD_SBOX_EN
  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]} ^
           {x[6:0], x[7]} ^ AES_AFF_C;
  endfunction
`endif

endpackage

// File: rtl/aes_inv_sbox_lane.sv
// rtl/aes_inv_sbox_lane.sv - one-byte inverse S-box lane around the composite-field inverter.
// AES_FWD_SBOX_EN adds a fwd select that bypasses the inverse affine and applies the forward one.
module aes_inv_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data,
`ifdef AES_FWD_SBOX_EN
  input  logic       fwd,
`endif
  output logic [7:0] result
);

  logic [7:0] inv_in;
  logic [7:0] inv_out;

`ifdef AES_FWD_SBOX_EN
  assign inv_in  = fwd ? data : inv_affine(data);
  assign inv_out = map_from_composite(gf256c_inv(map_to_composite(inv_in)));
  assign result  = fwd ? fwd_affine(inv_out) : inv_out;
`else
  assign inv_in  = inv_affine(data);
  assign inv_out = map_from_composite(gf256c_inv(map_to_composite(inv_in)));
  assign result  = inv_out;
`endif

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// rtl/aes_inv_sub_bytes_seq.sv - iterative InvSubBytes engine, LANES bytes per cycle.
// AES_FWD_SBOX_EN adds in_fwd, captured at accept, selecting the forward S-box for that state.
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef AES_FWD_SBOX_EN
  input  logic         in_fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e    state, state_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_group;
  logic [7:0]    work_b   [16];
  logic [7:0]    in_b     [16];
  logic [7:0]    lane_in  [LANES];
  logic [7:0]    lane_out [LANES];
  logic [3:0]    byte_idx [LANES];
`ifdef AES_FWD_SBOX_EN
  logic          fwd_q;
`endif

  // Byte 0 sits in the most significant byte of the 128-bit bus.
  for (genvar k = 0; k < 16; k++) begin : g_bytes
    assign in_b[k]                    = in_state[(15-k)*8 +: 8];
    assign out_state[(15-k)*8 +: 8]   = work_b[k];
  end

  assign last_group = (cnt == CW'(GROUPS - 1));

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      byte_idx[l] = 4'(int'(cnt) * LANES + l);
      lane_in[l]  = work_b[byte_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_inv_sbox_lane u_lane (
      .data   (lane_in[l]),
`ifdef AES_FWD_SBOX_EN
      .fwd    (fwd_q),
`endif
      .result (lane_out[l])
    );
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last_group) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        // Release and re-accept in the same cycle keeps the round loop bubble-free.
        in_ready  = out_ready;
        accept    = in_valid && out_ready;
        if (out_ready) state_next = (in_valid) ? S_BUSY : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      for (int k = 0; k < 16; k++) work_b[k] <= '0;
`ifdef AES_FWD_SBOX_EN
      fwd_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= '0;
        for (int k = 0; k < 16; k++) work_b[k] <= in_b[k];
`ifdef AES_FWD_SBOX_EN
        fwd_q <= in_fwd;
`endif
      end else if (state == S_BUSY) begin
        for (int l = 0; l < LANES; l++) work_b[byte_idx[l]] <= lane_out[l];
        if (GROUPS > 1) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// tb/tb_aes_inv_sub_bytes_seq.sv - scoreboard bench for LANES = 1, 4 and 16 instances.
// Golden tables come from a polynomial-basis GF(2^8) model of the forward S-box.
module tb_aes_inv_sub_bytes_seq;

  logic clk;
  int   checks   = 0;
  int   failures = 0;
  bit   done [3];

  logic [7:0] ginv  [256];
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, bb;
    r  = '0;
    x  = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ x;
      x  = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
      bb = bb >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] x);
    return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]} ^ {x[6:0], x[7]} ^ 8'h63;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // InvSbox is built by inverting the forward table.
  initial begin
    for (int a = 0; a < 256; a++) ginv[a] = 8'h00;
    for (int a = 1; a < 256; a++)
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) ginv[a] = 8'(b);
    for (int v = 0; v < 256; v++) fwd_t[v] = aff(ginv[v]);
    for (int v = 0; v < 256; v++) inv_t[fwd_t[v]] = 8'(v);
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    localparam int GR = 16 / LN;

    logic         rst, in_valid, in_ready, out_valid, out_ready, busy, fwd;
    logic [127:0] in_state, out_state;
    logic [127:0] exp_q [$];

    aes_inv_sub_bytes_seq #(.LANES(LN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
`ifdef AES_FWD_SBOX_EN
      .in_fwd    (fwd),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
    );

    task automatic send(input logic [127:0] s, input logic f, input logic [127:0] e);
      int n;
      in_valid = 1'b1;
      in_state = s;
      fwd      = f;
      n        = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        checks++;
        failures++;
        $display("FAIL L%0d_accept_timeout in_ready=%b required=1", LN, in_ready);
      end else begin
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy || out_valid) && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) begin
        checks++;
        failures++;
        $display("FAIL L%0d_drain_timeout pending=%0d required=0", LN, exp_q.size());
      end
      @(posedge clk);
      #1;
    endtask

    task automatic measure_latency(input string name);
      int lat;
      lat = 0;
      while (!out_valid && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("L%0d_%s", LN, name), 128'(lat), 128'(GR));
    endtask

    initial begin : monitor
      logic [127:0] e;
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL L%0d_unexpected_result got=%h required=none", LN, out_state);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("L%0d_result", LN), out_state, e);
          end
        end
      end
    end

    initial begin : driver
      logic [127:0] s, e, held;
      logic [7:0]   b;
      bit           hold_ok;
      int           n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b1;
      fwd       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("L%0d_rst_out_valid", LN), 128'(out_valid), 128'd0);
      chk($sformatf("L%0d_rst_out_state", LN), out_state, 128'd0);
      chk($sformatf("L%0d_rst_busy", LN), 128'(busy), 128'd0);
      chk($sformatf("L%0d_rst_in_ready", LN), 128'(in_ready), 128'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      send({16{8'h63}}, 1'b0, {16{8'h00}});
      measure_latency("latency_first");
      drain();

      send({8'h63, 8'h7C, 8'h16, 8'hED, {12{8'h00}}}, 1'b0,
           {8'h00, 8'h01, 8'hFF, 8'h53, {12{8'h52}}});
      drain();

      out_ready = 1'b0;
      send({16{8'hED}}, 1'b0, {16{8'h53}});
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("L%0d_done_reached", LN), 128'(out_valid), 128'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_state = {16{8'h00}};
      held     = out_state;
      hold_ok  = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_state !== held) hold_ok = 1'b0;
      end
      chk($sformatf("L%0d_hold_stable", LN), 128'(hold_ok), 128'd1);
      chk($sformatf("L%0d_held_value", LN), held, {16{8'h53}});
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send({16{8'h00}}, 1'b0, {16{8'h52}});
      measure_latency("latency_same_cycle");
      drain();

      send({16{8'h16}}, 1'b0, {16{8'hFF}});
      chk($sformatf("L%0d_busy_mid", LN), 128'(busy), 128'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("L%0d_abort_out_valid", LN), 128'(out_valid), 128'd0);
      chk($sformatf("L%0d_abort_out_state", LN), out_state, 128'd0);
      chk($sformatf("L%0d_abort_busy", LN), 128'(busy), 128'd0);
      chk($sformatf("L%0d_abort_in_ready", LN), 128'(in_ready), 128'd1);
      exp_q.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 256; v++) begin
        s = '0;
        e = '0;
        for (int p = 0; p < 16; p++) begin
          b = 8'(v + p);
          s = {s[119:0], b};
          e = {e[119:0], inv_t[b]};
        end
        send(s, 1'b0, e);
      end
      drain();

`ifdef AES_FWD_SBOX_EN
      send({8'h53, {15{8'h00}}}, 1'b1, {8'hED, {15{8'h63}}});
      drain();
      send({8'h53, {15{8'h00}}}, 1'b0, {inv_t[8'h53], {15{8'h52}}});
      drain();
`endif

      done[g] = 1'b1;
    end
  end

  initial begin : finisher
    int n;
    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60000) begin
      checks++;
      failures++;
      $display("FAIL global_timeout cycles=%0d required_below=60000", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
